// File: rtl/int2flt_seq.sv
// -----------------------------------------------------------------------------
// int2flt_seq
//   Sequential converter from a 16-bit two's-complement integer to IEEE-754
//   half precision {sign, exp[4:0], frac[9:0]}. The magnitude is normalised
//   one left shift per cycle, then packed (optionally rounded) in one cycle.
//
// Handshake:
//   start is sampled only in IDLE or DONE. An accepted start captures int_in,
//   clears done and launches a conversion. While busy is high, start is
//   ignored. done is a level that rises on the PACK edge and stays high until
//   the next accepted start or reset. flt_out is updated only on the PACK
//   edge (or cleared by reset) and is otherwise held.
//
// Ports:
//   clk     in   1   system clock, rising edge
//   reset   in   1   synchronous, active-high
//   start   in   1   conversion request
//   int_in  in  16   signed integer operand, captured on accepted start
//   flt_out out 16   half-precision result
//   busy    out  1   high in NORM and PACK
//   done    out  1   high from completion until next accepted start / reset
//
// Parameters:
//   EXP_BIAS  exponent bias (15 for half precision)
//   ROUND_EN  0 = truncate toward zero, 1 = round-to-nearest-even
// -----------------------------------------------------------------------------
module int2flt_seq #(
  parameter int EXP_BIAS = 15,
  parameter int ROUND_EN = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] int_in,
  output logic [15:0] flt_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_n;
  logic        sign_q, sign_n;
  logic [15:0] mag_q, mag_n;
  logic [4:0]  exp_q, exp_n;
  logic [15:0] flt_q, flt_n;
  logic        done_q, done_n;

  // Absolute value of the operand; -32768 wraps to 0x8000, which is the
  // correct unsigned magnitude.
  logic [15:0] abs_in;
  assign abs_in = int_in[15] ? (16'h0000 - int_in) : int_in;

  // Packing path: mag_q[15] is the hidden one once normalised.
  logic [9:0]  frac_t;
  logic        guard, sticky, round_up;
  logic [10:0] frac_sum;
  logic [9:0]  frac_r;
  logic [4:0]  exp_r;

  always_comb begin
    frac_t   = mag_q[14:5];
    guard    = mag_q[4];
    sticky   = |mag_q[3:0];
    round_up = (ROUND_EN != 0) && guard && (sticky || frac_t[0]);
    frac_sum = {1'b0, frac_t} + 11'd1;
    frac_r   = frac_t;
    exp_r    = exp_q;
    if (round_up) begin
      // A carry out of the fraction leaves frac_sum[9:0] at zero, so the
      // mantissa becomes 1.0 at the next exponent.
      frac_r = frac_sum[9:0];
      exp_r  = exp_q + {4'd0, frac_sum[10]};
    end
  end

  always_comb begin
    state_n = state;
    sign_n  = sign_q;
    mag_n   = mag_q;
    exp_n   = exp_q;
    flt_n   = flt_q;
    done_n  = done_q;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          sign_n  = int_in[15];
          mag_n   = abs_in;
          exp_n   = 5'(EXP_BIAS + 15);
          done_n  = 1'b0;
          state_n = (abs_in == 16'h0000) ? PACK : NORM;
        end
      end
      NORM: begin
        if (mag_q[15]) begin
          state_n = PACK;
        end else begin
          mag_n = mag_q << 1;
          exp_n = exp_q - 5'd1;
        end
      end
      PACK: begin
        if (mag_q == 16'h0000) begin
          flt_n = 16'h0000;
        end else begin
          flt_n = {sign_q, exp_r, frac_r};
        end
        done_n  = 1'b1;
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sign_q <= 1'b0;
      mag_q  <= 16'h0000;
      exp_q  <= 5'd0;
      flt_q  <= 16'h0000;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      sign_q <= sign_n;
      mag_q  <= mag_n;
      exp_q  <= exp_n;
      flt_q  <= flt_n;
      done_q <= done_n;
    end
  end

  assign flt_out = flt_q;
  assign done    = done_q;
  assign busy    = (state == NORM) || (state == PACK);

endmodule

// File: tb/tb_int2flt_seq.sv
// -----------------------------------------------------------------------------
// tb_int2flt_seq
//   Two instances (truncating and rounding) share stimulus; both have the same
//   timing. Expected results come from an arithmetic model of the conversion
//   and are queued when a conversion is launched, then popped on done.
// -----------------------------------------------------------------------------
module tb_int2flt_seq;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] int_in;
  logic [15:0] flt_t, flt_r;
  logic        busy_t, done_t, busy_r, done_r;

  always #5 clk = ~clk;

  int2flt_seq #(.EXP_BIAS(15), .ROUND_EN(0)) dut_t (
    .clk(clk), .reset(reset), .start(start), .int_in(int_in),
    .flt_out(flt_t), .busy(busy_t), .done(done_t)
  );

  int2flt_seq #(.EXP_BIAS(15), .ROUND_EN(1)) dut_r (
    .clk(clk), .reset(reset), .start(start), .int_in(int_in),
    .flt_out(flt_r), .busy(busy_r), .done(done_r)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int          lat_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Arithmetic model: locate the leading one, extract 10 fraction bits and
  // round on the exact remainder.
  function automatic logic [15:0] model(input logic [15:0] v, input bit rnd);
    logic [15:0] mag;
    int p, sh, frac, e, rem, half;
    mag = v[15] ? 16'(-v) : v;
    if (mag == 16'h0000) return 16'h0000;
    p = 0;
    for (int i = 0; i < 16; i++) if (mag[i]) p = i;
    e = 15 + p;
    if (p <= 10) begin
      frac = (int'(mag) - (1 << p)) << (10 - p);
    end else begin
      sh   = p - 10;
      frac = (int'(mag) >> sh) & 'h3FF;
      rem  = int'(mag) & ((1 << sh) - 1);
      half = 1 << (sh - 1);
      if (rnd && (rem > half || (rem == half && (frac % 2) == 1))) begin
        frac++;
        if (frac == 1024) begin
          frac = 0;
          e++;
        end
      end
    end
    return {v[15], 5'(e), 10'(frac)};
  endfunction

  function automatic int model_lat(input logic [15:0] v);
    logic [15:0] mag;
    int p;
    mag = v[15] ? 16'(-v) : v;
    if (mag == 16'h0000) return 2;
    p = 0;
    for (int i = 0; i < 16; i++) if (mag[i]) p = i;
    return (15 - p) + 3;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_expect(input logic [15:0] v);
    exp_q0.push_back(model(v, 1'b0));
    exp_q1.push_back(model(v, 1'b1));
    lat_q.push_back(model_lat(v));
  endtask

  // Called at a negedge after the accepting edge; edges = 1 on entry.
  // Returns the edge count at which done was seen, or 0 on timeout.
  task automatic wait_done(input bit poke, output int edges);
    int  n;
    bit  seen;
    n    = 1;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      check("busy_done_excl", {31'd0, busy_t & done_t}, 32'd0);
      if (done_t) begin
        seen = 1'b1;
      end else begin
        if (poke && n == 5) begin
          start  = 1'b1;
          int_in = 16'd7;
        end else if (poke && n == 6) begin
          start = 1'b0;
        end
        @(posedge clk);
        n++;
      end
    end
    edges = seen ? n : 0;
  endtask

  task automatic compare_result(input int edges);
    logic [15:0] e0, e1;
    int          lat;
    e0  = exp_q0.pop_front();
    e1  = exp_q1.pop_front();
    lat = lat_q.pop_front();
    check("done_seen", {31'd0, edges != 0}, 32'd1);
    if (edges != 0) begin
      check("latency", edges, lat);
      check("done_pair", {31'd0, done_r}, {31'd0, done_t});
      check("flt_trunc", {16'd0, flt_t}, {16'd0, e0});
      check("flt_round", {16'd0, flt_r}, {16'd0, e1});
    end
  endtask

  task automatic run_conv(input logic [15:0] v, input bit poke);
    int edges;
    @(negedge clk);
    int_in = v;
    start  = 1'b1;
    push_expect(v);
    @(posedge clk);
    #1;
    start  = 1'b0;
    int_in = 16'($urandom);
    wait_done(poke, edges);
    compare_result(edges);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] directed [9] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0005, 16'h8000,
                                16'h7FFF, 16'd2049, 16'd2051, 16'h8001};

  initial begin
    int  edges;
    bit  late;
    reset  = 1'b1;
    start  = 1'b0;
    int_in = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flt_t", {16'd0, flt_t}, 32'd0);
    check("rst_flt_r", {16'd0, flt_r}, 32'd0);
    check("rst_done", {31'd0, done_t | done_r}, 32'd0);
    check("rst_busy", {31'd0, busy_t | busy_r}, 32'd0);
    reset = 1'b0;

    foreach (directed[i]) run_conv(directed[i], 1'b0);

    // start pulse with a new operand in the middle of a conversion
    run_conv(16'h0001, 1'b1);

    // start held high across DONE retriggers a conversion
    @(negedge clk);
    int_in = 16'd5;
    start  = 1'b1;
    push_expect(16'd5);
    @(posedge clk);
    wait_done(1'b0, edges);
    compare_result(edges);
    int_in = 16'd3;
    push_expect(16'd3);
    @(posedge clk);
    @(negedge clk);
    check("retrig_done_drop", {31'd0, done_t}, 32'd0);
    check("retrig_busy", {31'd0, busy_t}, 32'd1);
    start = 1'b0;
    wait_done(1'b0, edges);
    // accepting edge was one edge before the drop check
    if (edges != 0) edges = edges + 1;
    compare_result(edges);

    // reset in the middle of a conversion
    @(negedge clk);
    int_in = 16'h0001;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_flt_t", {16'd0, flt_t}, 32'd0);
    check("midrst_flt_r", {16'd0, flt_r}, 32'd0);
    check("midrst_done", {31'd0, done_t | done_r}, 32'd0);
    check("midrst_busy", {31'd0, busy_t | busy_r}, 32'd0);
    reset = 1'b0;
    late  = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done_t || done_r || busy_t) late = 1'b1;
    end
    check("no_late_done", {31'd0, late}, 32'd0);

    // powers of two and neighbours, both signs
    for (int b = 0; b < 16; b++) begin
      logic [15:0] pw;
      pw = 16'(1 << b);
      run_conv(pw, 1'b0);
      run_conv(16'(-pw), 1'b0);
      run_conv(pw + 16'd1, 1'b0);
      run_conv(pw - 16'd1, 1'b0);
    end

    // random sweep
    for (int i = 0; i < 4000; i++) run_conv(16'($urandom_range(0, 65535)), 1'b0);

    check("queue_empty", exp_q0.size() + exp_q1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
